// File: rtl/spi_bridge_pkg.sv
// Shared encodings and command-byte field positions for the SPI register bridge.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        RD_REQ  = 3'd2,
        RD_LOAD = 3'd3,
        DATA    = 3'd4,
        WAIT_CS = 3'd5
    } state_t;

    localparam int         CMD_RW_BIT = 7;
    localparam int         ADDR_MSB   = 5;
    localparam logic [5:0] ADDR_WRAP  = 6'h3F;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall detection.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that converts host frames into register-file reads and writes,
// with auto-incrementing address across the data bytes of a frame.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              read_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);

    logic                   sclk_unused_level;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_level;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_sync;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [2:0]             cnt_after;
    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      rx_next;
    logic [DATA_W-1:0]      tx_shift;
    logic                   is_read;
    logic [ADDR_W-1:0]      next_addr;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (sclk),
        .level   (sclk_unused_level),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (cs_n),
        .level   (cs_level),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_sync = mosi_q[SYNC_STAGES-1];
    assign miso      = tx_shift[DATA_W-1];

    always_comb begin
        rx_next   = {rx_shift[DATA_W-2:0], mosi_sync};
        cnt_after = bit_cnt + {2'b00, sclk_rise};
        next_addr = (address == ADDR_W'(ADDR_WRAP)) ? '0 : address + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            is_read   <= 1'b0;
            miso_oe   <= 1'b0;
            address   <= '0;
            write_en  <= 1'b0;
            wr_data   <= '0;
            read_en   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            write_en  <= 1'b0;
            read_en   <= 1'b0;
            frame_err <= 1'b0;
            // Write address advances the cycle after the strobe so the strobe sees the old one.
            if (write_en) begin
                address <= next_addr;
            end

            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                        busy     <= 1'b1;
                        miso_oe  <= 1'b1;
                    end else if (!cs_level) begin
                        state <= WAIT_CS;
                    end
                end
                WAIT_CS: begin
                    if (cs_level) begin
                        state <= IDLE;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            address <= ADDR_W'(rx_next[ADDR_MSB:0]);
                            is_read <= rx_next[CMD_RW_BIT];
                            if (rx_next[CMD_RW_BIT]) begin
                                state   <= RD_REQ;
                                read_en <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    state <= RD_LOAD;
                end
                RD_LOAD: begin
                    tx_shift <= rd_data;
                    state    <= DATA;
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (is_read) begin
                                address <= next_addr;
                                state   <= RD_REQ;
                                read_en <= 1'b1;
                            end else begin
                                wr_data  <= rx_next;
                                write_en <= 1'b1;
                            end
                        end
                    end
                    // The fall that closes a byte must not shift: the next byte's MSB is already loaded.
                    if (sclk_fall && bit_cnt != 3'd0) begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Deselect overrides the state move but keeps any byte completed this same cycle.
            if (state != IDLE && state != WAIT_CS && cs_rise) begin
                state     <= IDLE;
                busy      <= 1'b0;
                miso_oe   <= 1'b0;
                tx_shift  <= '0;
                frame_err <= (cnt_after != 3'd0);
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI host tasks, register-file model, write/read scoreboards.
module tb_spi_reg_bridge;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [5:0] address;
    logic       write_en;
    logic [7:0] wr_data;
    logic       read_en;
    logic [7:0] rd_data = 8'h00;
    logic       busy;
    logic       frame_err;

    logic [7:0]  mem     [64];
    logic [7:0]  exp_mem [64];
    logic [13:0] wr_q    [$];
    logic [7:0]  rd_q    [$];
    logic [13:0] exp_w;

    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int fe_cnt = 0;

    always #5 clock = ~clock;

    spi_reg_bridge #(
        .ADDR_W      (6),
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .address   (address),
        .write_en  (write_en),
        .wr_data   (wr_data),
        .read_en   (read_en),
        .rd_data   (rd_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register file: registered read data, valid the cycle after read_en.
    always @(posedge clock) begin
        if (write_en) mem[address] <= wr_data;
        if (read_en)  rd_data <= mem[address];
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (write_en) begin
                wr_cnt++;
                check("rw_overlap", {31'd0, read_en}, 32'd0);
                if (wr_q.size() == 0) begin
                    check("wr_spurious", {31'd0, write_en}, 32'd0);
                end else begin
                    exp_w = wr_q.pop_front();
                    check("wr_access", {18'd0, address, wr_data}, {18'd0, exp_w});
                end
            end
            if (read_en)   rd_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (half) @(negedge clock);
            sclk = 1'b1;
            rx[7-i] = miso;
            repeat (half) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clock);
        cs_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic write_frame(input logic [5:0] a, input logic [31:0] data, input int n,
                               input int half, input logic bit6);
        logic [7:0] rx;
        logic [7:0] b;
        logic [5:0] ad;
        int         w0;
        int         f0;
        ad = a;
        w0 = wr_cnt;
        f0 = fe_cnt;
        cs_start();
        spi_bits({1'b0, bit6, a}, 8, half, rx);
        for (int k = 0; k < n; k++) begin
            b = data[31-8*k -: 8];
            wr_q.push_back({ad, b});
            exp_mem[ad] = b;
            ad = ad + 6'd1;
            spi_bits(b, 8, half, rx);
        end
        cs_end();
        check("wr_count", wr_cnt - w0, n);
        check("wr_no_frame_err", fe_cnt - f0, 0);
        check("wr_busy_after", {31'd0, busy}, 32'd0);
        check("wr_addr_after", {26'd0, address}, {26'd0, ad});
    endtask

    task automatic read_frame(input logic [5:0] a, input int n, input int half);
        logic [7:0] rx;
        logic [5:0] ad;
        int         r0;
        ad = a;
        r0 = rd_cnt;
        cs_start();
        spi_bits({2'b10, a}, 8, half, rx);
        check("rd_cmd_miso", {24'd0, rx}, 32'd0);
        for (int k = 0; k < n; k++) begin
            rd_q.push_back(exp_mem[ad]);
            ad = ad + 6'd1;
            spi_bits(8'h00, 8, half, rx);
            check("rd_byte", {24'd0, rx}, {24'd0, rd_q.pop_front()});
        end
        cs_end();
        check("rd_strobes", rd_cnt - r0, n + 1);
        check("rd_addr_after", {26'd0, address}, {26'd0, ad});
        check("rd_oe_after", {31'd0, miso_oe}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        int         w0;
        int         f0;

        for (int i = 0; i < 64; i++) begin
            mem[i]     = 8'((i * 37 + 11) & 8'hFF);
            exp_mem[i] = 8'((i * 37 + 11) & 8'hFF);
        end
        mem[15]     = 8'h3C;
        exp_mem[15] = 8'h3C;

        reset_n = 1'b0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_address", {26'd0, address}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_read_en", {31'd0, read_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (10) @(negedge clock);

        // Single write 0x04 <= 0xA5 with mid-frame status checks.
        w0 = wr_cnt;
        cs_start();
        spi_bits(8'h04, 8, 10, rx);
        check("sw_busy_mid", {31'd0, busy}, 32'd1);
        check("sw_oe_mid", {31'd0, miso_oe}, 32'd1);
        wr_q.push_back({6'h04, 8'hA5});
        exp_mem[4] = 8'hA5;
        spi_bits(8'hA5, 8, 10, rx);
        cs_end();
        check("sw_count", wr_cnt - w0, 1);
        check("sw_busy_after", {31'd0, busy}, 32'd0);
        check("sw_addr_after", {26'd0, address}, 32'h05);

        // Single read from 0x0F.
        read_frame(6'h0F, 1, 10);

        // Write burst wrapping 0x3F -> 0x00, command bit6 set (ignored).
        write_frame(6'h3E, 32'h1122_3300, 3, 10, 1'b1);

        // Read burst of 4 at minimum half-period, then a wrapping read burst.
        read_frame(6'h0C, 4, 8);
        read_frame(6'h3F, 2, 8);

        // Abort mid data byte: no write, one frame_err.
        w0 = wr_cnt;
        f0 = fe_cnt;
        cs_start();
        spi_bits(8'h10, 8, 10, rx);
        spi_bits(8'hFF, 5, 10, rx);
        cs_end();
        check("abort_no_write", wr_cnt - w0, 0);
        check("abort_frame_err", fe_cnt - f0, 1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", {26'd0, address}, 32'h10);

        // Eighth data rise and deselect in the same cycle: byte completes, no error.
        w0 = wr_cnt;
        f0 = fe_cnt;
        cs_start();
        spi_bits(8'h30, 8, 10, rx);
        wr_q.push_back({6'h30, 8'h77});
        exp_mem[48] = 8'h77;
        spi_bits(8'h77, 7, 10, rx);
        mosi = 1'b1;
        repeat (10) @(negedge clock);
        sclk = 1'b1;
        cs_n = 1'b1;
        repeat (10) @(negedge clock);
        sclk = 1'b0;
        repeat (10) @(negedge clock);
        check("simul_write", wr_cnt - w0, 1);
        check("simul_no_err", fe_cnt - f0, 0);
        check("simul_busy", {31'd0, busy}, 32'd0);
        check("simul_addr", {26'd0, address}, 32'h31);

        // Reset mid-frame with cs_n held low: rest of the frame is ignored.
        w0 = wr_cnt;
        f0 = fe_cnt;
        cs_start();
        spi_bits(8'h20, 8, 10, rx);
        spi_bits(8'hC3, 4, 10, rx);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("mrst_outputs", {19'd0, miso, miso_oe, address, write_en, read_en, busy, frame_err},
              32'd0);
        check("mrst_wr_data", {24'd0, wr_data}, 32'd0);
        spi_bits(8'h3C, 4, 10, rx);
        spi_bits(8'hEE, 8, 10, rx);
        check("mrst_busy_ignored", {31'd0, busy}, 32'd0);
        check("mrst_oe_ignored", {31'd0, miso_oe}, 32'd0);
        cs_end();
        check("mrst_no_write", wr_cnt - w0, 0);
        check("mrst_no_err", fe_cnt - f0, 0);
        write_frame(6'h21, 32'h5A00_0000, 1, 10, 1'b0);
        read_frame(6'h21, 1, 10);

        check("wr_q_drained", wr_q.size(), 0);
        check("frame_err_total", fe_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
